// File: rtl/t06_period_meter.sv
// Purpose: measures clk cycles between successive rising edges of async sig_i.
// Latency: sig_i rise -> internal edge SYNC_STAGES+1 cycles; valid_o/period_o one cycle later.
// Backpressure: none; each report is a one-cycle strobe and period_o holds until the next.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   nrst       async active-low reset (release expected to be synchronous to clk)
//   en_i       level-sensitive measurement enable
//   sig_i      asynchronous signal under measurement
//   period_o   most recent measured interval (WIDTH bits), held between reports
//   valid_o    one-cycle pulse, coincident with a period_o update
//   timeout_o  sticky: counter saturated before an edge arrived
module t06_period_meter #(
    parameter int WIDTH       = 19,
    parameter int SYNC_STAGES = 2     // must be >= 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en_i,
    input  logic             sig_i,
    output logic [WIDTH-1:0] period_o,
    output logic             valid_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    // Synchronizer chain plus one history flop for edge detection.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    logic                   s;
    logic                   sig_edge;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    assign s        = sync_q[SYNC_STAGES-1];
    assign sig_edge = s & ~s_d_q;

    // The input path runs regardless of en_i, so a level that is already high
    // at enable time has s_d = 1 and cannot masquerade as an edge.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
        s_d_d  = s;
    end

    // Next-state logic. Precedence: disable, then edge, then saturation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!en_i) begin
            // Disabled: abandon any interval in progress; the last report stays visible.
            state_d   = ST_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // One cycle of settling after enable; edges here are ignored.
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end

                ST_ARM: begin
                    // First edge only starts timing; it has no predecessor to measure from.
                    if (sig_edge) begin
                        state_d = ST_MEASURE;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end

                ST_MEASURE: begin
                    if (sig_edge) begin
                        // cnt equals cycles elapsed since the previous edge, because
                        // it was loaded with 1 on that edge's cycle.
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        // Too slow or stuck: flag and wait for a fresh pair of edges.
                        timeout_d = 1'b1;
                        state_d   = ST_ARM;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_d_q     <= s_d_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o  = period_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_t06_period_meter.sv
// Bench for t06_period_meter: two instances (wide default, and narrow WIDTH=4 with
// three sync stages) share stimulus. A timestamp-based reference model predicts
// every output on every cycle; table vectors and corner sequences add targeted checks.
module tb_t06_period_meter;

    localparam int WA = 19;
    localparam int SA = 2;
    localparam int WB = 4;
    localparam int SB = 3;

    logic clk;
    logic nrst;
    logic en;
    logic sig;

    logic [WA-1:0] per_a;
    logic          val_a;
    logic          to_a;
    logic [WB-1:0] per_b;
    logic          val_b;
    logic          to_b;

    t06_period_meter #(.WIDTH(WA), .SYNC_STAGES(SA)) dut_a (
        .clk(clk), .nrst(nrst), .en_i(en), .sig_i(sig),
        .period_o(per_a), .valid_o(val_a), .timeout_o(to_a)
    );

    t06_period_meter #(.WIDTH(WB), .SYNC_STAGES(SB)) dut_b (
        .clk(clk), .nrst(nrst), .en_i(en), .sig_i(sig),
        .period_o(per_b), .valid_o(val_b), .timeout_o(to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_chk;
    int     n_pass;
    longint cyc;
    int     tot_va;
    int     tot_vb;

    // Reference model, per instance (0 = wide, 1 = narrow). Each rising edge is
    // timestamped; a report is the difference of two timestamps, and a timeout is
    // the elapsed time since the last timestamp reaching the all-ones value.
    longint m_max    [2];
    int     m_ss     [2];
    bit     m_hist   [2][8];
    bit     m_active [2];
    longint m_last   [2];
    longint m_per    [2];
    bit     m_val    [2];
    bit     m_to     [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset_one(input int k);
        for (int i = 0; i < 8; i++) m_hist[k][i] = 1'b0;
        m_active[k] = 1'b0;
        m_last[k]   = -1;
        m_per[k]    = 0;
        m_val[k]    = 1'b0;
        m_to[k]     = 1'b0;
    endtask

    // One rising clock edge. A sig_i rise sampled at edge t is acted upon at
    // edge t+SYNC_STAGES, so the edge seen now comes from the sampled history.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit e;
            e = m_hist[k][m_ss[k]-1] & ~m_hist[k][m_ss[k]];
            m_val[k] = 1'b0;
            if (!nrst) begin
                model_reset_one(k);
            end else begin
                if (!en) begin
                    m_active[k] = 1'b0;
                    m_last[k]   = -1;
                    m_to[k]     = 1'b0;
                end else if (!m_active[k]) begin
                    m_active[k] = 1'b1;
                end else if (e) begin
                    if (m_last[k] >= 0) begin
                        m_per[k] = cyc - m_last[k];
                        m_val[k] = 1'b1;
                        m_to[k]  = 1'b0;
                    end
                    m_last[k] = cyc;
                end else if (m_last[k] >= 0 && (cyc - m_last[k]) == m_max[k]) begin
                    m_to[k]   = 1'b1;
                    m_last[k] = -1;
                end
                for (int i = 7; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
                m_hist[k][0] = sig;
            end
        end
    endtask

    // Advance one cycle and compare both instances against the model.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        if (val_a) tot_va++;
        if (val_b) tot_vb++;
        chk("a_period",  per_a, m_per[0]);
        chk("a_valid",   val_a, m_val[0]);
        chk("a_timeout", to_a,  m_to[0]);
        chk("b_period",  per_b, m_per[1]);
        chk("b_valid",   val_b, m_val[1]);
        chk("b_timeout", to_b,  m_to[1]);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        en   = 1'b0;
        sig  = 1'b0;
        repeat (3) tick();
        nrst = 1'b1;
    endtask

    // One-cycle high sample followed by gap-1 low samples: rising edges gap apart.
    task automatic pulse(input int gap);
        sig = 1'b1;
        tick();
        sig = 1'b0;
        repeat (gap - 1) tick();
    endtask

    typedef struct {
        int per;        // waveform period in cycles
        int hi;         // high samples per period
        int exp_a;      // final period_o, wide instance
        int exp_b;      // final period_o, WIDTH=4 instance
        bit exp_to_b;   // final timeout_o, WIDTH=4 instance
    } vec_t;

    vec_t vecs[7];

    initial begin
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        tot_va = 0;
        tot_vb = 0;
        m_max[0] = (64'd1 << WA) - 1;
        m_max[1] = (64'd1 << WB) - 1;
        m_ss[0]  = SA;
        m_ss[1]  = SB;
        model_reset_one(0);
        model_reset_one(1);

        // Divider tick with max_i = 4 is a 1-in-5 strobe; toggling gives period 2;
        // period 15 edges land exactly on saturation; 16 and 40 overrun WIDTH=4.
        vecs[0] = '{per: 5,  hi: 1,  exp_a: 5,  exp_b: 5,  exp_to_b: 1'b0};
        vecs[1] = '{per: 2,  hi: 1,  exp_a: 2,  exp_b: 2,  exp_to_b: 1'b0};
        vecs[2] = '{per: 7,  hi: 3,  exp_a: 7,  exp_b: 7,  exp_to_b: 1'b0};
        vecs[3] = '{per: 3,  hi: 2,  exp_a: 3,  exp_b: 3,  exp_to_b: 1'b0};
        vecs[4] = '{per: 15, hi: 7,  exp_a: 15, exp_b: 15, exp_to_b: 1'b0};
        vecs[5] = '{per: 16, hi: 5,  exp_a: 16, exp_b: 0,  exp_to_b: 1'b1};
        vecs[6] = '{per: 40, hi: 20, exp_a: 40, exp_b: 0,  exp_to_b: 1'b1};

        nrst = 1'b0;
        en   = 1'b0;
        sig  = 1'b0;
        #1;
        chk("reset_period_a",  per_a, 0);
        chk("reset_valid_a",   val_a, 0);
        chk("reset_timeout_a", to_a,  0);

        // Table-driven periodic waveforms.
        for (int v = 0; v < 7; v++) begin
            int     nv;
            longint t_prev;
            longint t_last;
            nv     = 0;
            t_prev = 0;
            t_last = 0;
            do_reset();
            en = 1'b1;
            for (int c = 0; c < 8 * vecs[v].per + 12; c++) begin
                sig = ((c % vecs[v].per) < vecs[v].hi);
                tick();
                if (val_a) begin
                    nv++;
                    t_prev = t_last;
                    t_last = cyc;
                end
            end
            chk("tbl_period_a",  per_a, vecs[v].exp_a);
            chk("tbl_period_b",  per_b, vecs[v].exp_b);
            chk("tbl_timeout_b", to_b,  vecs[v].exp_to_b);
            chk("tbl_two_valids_a", (nv >= 2), 1);
            chk("tbl_valid_gap_a", t_last - t_prev, vecs[v].exp_a);
        end

        // Stuck-low input on WIDTH=4: timeout, then only the second new edge reports.
        begin
            int vb0;
            do_reset();
            en = 1'b1;
            tick();
            pulse(26);
            chk("stuck_timeout_b", to_b, 1);
            vb0 = tot_vb;
            pulse(6);
            chk("stuck_first_edge_no_valid_b", tot_vb - vb0, 0);
            chk("stuck_timeout_held_b", to_b, 1);
            pulse(9);
            chk("stuck_second_edge_valid_b", tot_vb - vb0, 1);
            chk("stuck_period_b", per_b, 6);
            chk("stuck_timeout_cleared_b", to_b, 0);
        end

        // Enable dropped mid-interval: report holds, re-measurement needs two edges.
        begin
            int va0;
            do_reset();
            en = 1'b1;
            tick();
            pulse(7);
            pulse(7);
            pulse(7);
            chk("en_period_before_a", per_a, 7);
            va0 = tot_va;
            en  = 1'b0;
            repeat (3) tick();
            chk("en_off_no_valid_a", tot_va - va0, 0);
            chk("en_off_hold_period_a", per_a, 7);
            chk("en_off_timeout_clear_b", to_b, 0);
            en = 1'b1;
            pulse(9);
            chk("en_first_edge_no_valid_a", tot_va - va0, 0);
            chk("en_first_edge_hold_a", per_a, 7);
            pulse(9);
            chk("en_second_edge_valid_a", tot_va - va0, 1);
            chk("en_new_period_a", per_a, 9);
        end

        // Reset mid-interval with sig_i high: outputs clear at once, no report after.
        begin
            int va0;
            int vb0;
            do_reset();
            en = 1'b1;
            tick();
            pulse(5);
            pulse(5);
            pulse(5);
            sig = 1'b1;
            repeat (2) tick();
            #2;
            nrst = 1'b0;
            #1;
            chk("async_rst_period_a",  per_a, 0);
            chk("async_rst_valid_a",   val_a, 0);
            chk("async_rst_timeout_a", to_a,  0);
            chk("async_rst_period_b",  per_b, 0);
            chk("async_rst_valid_b",   val_b, 0);
            chk("async_rst_timeout_b", to_b,  0);
            tick();
            nrst = 1'b1;
            va0  = tot_va;
            vb0  = tot_vb;
            repeat (12) tick();
            chk("post_rst_no_valid_a", tot_va - va0, 0);
            chk("post_rst_no_valid_b", tot_vb - vb0, 0);
        end

        // Randomized segments of mixed density, stuck-low and periodic input.
        do_reset();
        en = 1'b1;
        for (int seg = 0; seg < 30; seg++) begin
            int mode;
            int len;
            int p;
            mode = $urandom_range(0, 3);
            len  = $urandom_range(20, 60);
            p    = $urandom_range(2, 20);
            for (int c = 0; c < len; c++) begin
                en = ($urandom_range(0, 99) < 96);
                case (mode)
                    0:       sig = 1'($urandom_range(0, 1));
                    1:       sig = ($urandom_range(0, 9) == 0);
                    2:       sig = 1'b0;
                    default: sig = ((c % p) == 0);
                endcase
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
